// File: rtl/phase_sequencer.sv
// phase_sequencer: four-way traffic phase controller.
//
// Serves roads N, E, S and W in turn with GREEN -> YELLOW -> (ALLRED) phases.
// All timers advance only on the one-cycle tick strobe. Each state loads its
// duration T on entry and is left on the tick that sees timer == 1, so a state
// lasts exactly T ticks. Green durations come from TGn/TGe/TGs/TGw, clamped to
// [MIN_GREEN, MAX_GREEN] and sampled only on the cycle the green is entered.
//
// Optional feature macro: ALL_RED_PHASE_EN
//   defined   : YELLOW expiry goes to an ALLRED interval of ALLRED_T ticks.
//   undefined : no ALLRED state; YELLOW expiry goes straight to the next GREEN.
//   In both builds INIT shows all-red for ALLRED_T ticks.
//
// Ports:
//   clk                  single clock, rising edge
//   reset                synchronous, active-low
//   tick                 time-base enable (one cycle per tick)
//   TGn/TGe/TGs/TGw      requested green durations in ticks
//   next_road            road to be served next (0=N 1=E 2=S 3=W)
//   current_road         road currently holding the phase
//   light_n/e/s/w        one-hot {R,Y,G} on bits {2,1,0}
//   remaining            ticks left in the current state (never 0)
//   phase_done           one-cycle pulse on the cycle a GREEN is entered
module phase_sequencer #(
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned MIN_GREEN = 10,
    parameter int unsigned MAX_GREEN = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] TGn,
    input  logic [7:0] TGe,
    input  logic [7:0] TGs,
    input  logic [7:0] TGw,
    output logic [1:0] next_road,
    output logic [1:0] current_road,
    output logic [2:0] light_n,
    output logic [2:0] light_e,
    output logic [2:0] light_s,
    output logic [2:0] light_w,
    output logic [7:0] remaining,
    output logic       phase_done
);

    localparam logic [7:0] YellowT  = 8'(YELLOW_T);
    localparam logic [7:0] AllRedT  = 8'(ALLRED_T);
    localparam logic [7:0] MinGreen = 8'(MIN_GREEN);
    localparam logic [7:0] MaxGreen = 8'(MAX_GREEN);

    localparam logic [2:0] LightR = 3'b100;
    localparam logic [2:0] LightY = 3'b010;
    localparam logic [2:0] LightG = 3'b001;

    typedef logic [3:0][2:0] lights_t;
    localparam lights_t AllRed = {LightR, LightR, LightR, LightR};

    typedef enum logic [1:0] {
        StInit,
        StGreen,
        StYellow
`ifdef ALL_RED_PHASE_EN
        , StAllRed
`endif
    } state_e;

    state_e     state_q;
    logic [7:0] timer_q;
    logic [1:0] current_q;
    logic [1:0] next_q;
    lights_t    lights_q;
    logic       phase_done_q;

    logic       expire;
    logic       enter_green;
    logic [7:0] tg_sel;

    // All lights red except the given road, which shows the given colour.
    function automatic lights_t lights_for(input logic [1:0] road, input logic [2:0] color);
        lights_t l;
        l       = AllRed;
        l[road] = color;
        return l;
    endfunction

    function automatic logic [7:0] clamp_green(input logic [7:0] tg);
        if (tg < MinGreen) begin
            return MinGreen;
        end else if (tg > MaxGreen) begin
            return MaxGreen;
        end
        return tg;
    endfunction

    always_comb begin
        case (next_q)
            2'd0:    tg_sel = TGn;
            2'd1:    tg_sel = TGe;
            2'd2:    tg_sel = TGs;
            default: tg_sel = TGw;
        endcase
    end

    always_comb begin
        expire = tick && (timer_q == 8'd1);
`ifdef ALL_RED_PHASE_EN
        enter_green = expire && (state_q == StInit || state_q == StAllRed);
`else
        enter_green = expire && (state_q == StInit || state_q == StYellow);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StInit;
            timer_q      <= AllRedT;
            current_q    <= 2'd0;
            next_q       <= 2'd0;
            lights_q     <= AllRed;
            phase_done_q <= 1'b0;
        end else begin
            phase_done_q <= 1'b0;
            if (enter_green) begin
                state_q      <= StGreen;
                current_q    <= next_q;
                timer_q      <= clamp_green(tg_sel);
                lights_q     <= lights_for(next_q, LightG);
                phase_done_q <= 1'b1;
            end else if (expire && state_q == StGreen) begin
                state_q  <= StYellow;
                next_q   <= current_q + 2'd1;
                timer_q  <= YellowT;
                lights_q <= lights_for(current_q, LightY);
`ifdef ALL_RED_PHASE_EN
            end else if (expire && state_q == StYellow) begin
                state_q  <= StAllRed;
                timer_q  <= AllRedT;
                lights_q <= AllRed;
`endif
            end else if (tick) begin
                // Timer is never 1 here when tick is high, so it never reaches 0.
                timer_q <= timer_q - 8'd1;
            end
        end
    end

    assign next_road    = next_q;
    assign current_road = current_q;
    assign light_n      = lights_q[0];
    assign light_e      = lights_q[1];
    assign light_s      = lights_q[2];
    assign light_w      = lights_q[3];
    assign remaining    = timer_q;
    assign phase_done   = phase_done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] TGn, TGe, TGs, TGw;
    logic [1:0] next_road, current_road;
    logic [2:0] light_n, light_e, light_s, light_w;
    logic [7:0] remaining;
    logic       phase_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .TGn          (TGn),
        .TGe          (TGe),
        .TGs          (TGs),
        .TGw          (TGw),
        .next_road    (next_road),
        .current_road (current_road),
        .light_n      (light_n),
        .light_e      (light_e),
        .light_s      (light_s),
        .light_w      (light_w),
        .remaining    (remaining),
        .phase_done   (phase_done)
    );

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick  = 1'b1;
        step();
        step();
        tests++;
        if ({light_n, light_e, light_s, light_w} !== {R, R, R, R}) begin
            fails++;
            $display("FAIL reset_lights: got %b %b %b %b, want 100 100 100 100",
                     light_n, light_e, light_s, light_w);
        end
        tests++;
        if (current_road !== 2'd0 || next_road !== 2'd0) begin
            fails++;
            $display("FAIL reset_roads: got cur=%0d next=%0d, want 0 0", current_road, next_road);
        end
        // tick was high during reset and must have been ignored
        tests++;
        if (remaining !== 8'd1) begin
            fails++;
            $display("FAIL reset_remaining: got %0d, want 1", remaining);
        end
        tests++;
        if (phase_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_phase_done: got %b, want 0", phase_done);
        end
        reset = 1'b1;
        tick  = 1'b0;
        step();
        step();
        step();
        tests++;
        if (light_n !== R || remaining !== 8'd1) begin
            fails++;
            $display("FAIL tick_gate: got light_n=%b rem=%0d, want 100 1", light_n, remaining);
        end
        tick = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        int pulses;
        step();
        tests++;
        if (light_n !== G || phase_done !== 1'b1 || current_road !== 2'd0 || remaining !== 8'd40)
        begin
            fails++;
            $display("FAIL north_green_entry: got light=%b pd=%b cur=%0d rem=%0d, want 001 1 0 40",
                     light_n, phase_done, current_road, remaining);
        end
        n      = 0;
        pulses = 0;
        while (light_n === G && n < 300) begin
            n++;
            if (phase_done === 1'b1) pulses++;
            step();
        end
        tests++;
        if (n != 40 || pulses != 1) begin
            fails++;
            $display("FAIL north_green_len: got %0d ticks %0d pulses, want 40 1", n, pulses);
        end
        tests++;
        if (light_n !== Y || next_road !== 2'd1 || remaining !== 8'd3) begin
            fails++;
            $display("FAIL north_yellow_entry: got light=%b next=%0d rem=%0d, want 010 1 3",
                     light_n, next_road, remaining);
        end
        n = 0;
        while (light_n === Y && n < 50) begin
            n++;
            step();
        end
        tests++;
        if (n != 3) begin
            fails++;
            $display("FAIL north_yellow_len: got %0d, want 3", n);
        end
`ifdef ALL_RED_PHASE_EN
        tests++;
        if ({light_n, light_e, light_s, light_w} !== {R, R, R, R}) begin
            fails++;
            $display("FAIL allred_interval: got %b %b %b %b, want all 100",
                     light_n, light_e, light_s, light_w);
        end
        step();
`endif
        tests++;
        if (light_e !== G || light_n !== R || current_road !== 2'd1 || phase_done !== 1'b1) begin
            fails++;
            $display("FAIL east_green_follow: got e=%b n=%b cur=%0d pd=%b, want 001 100 1 1",
                     light_e, light_n, current_road, phase_done);
        end
    endtask

    task automatic test_clamp();
        int n;
        n = 0;
        while (light_e === G && n < 300) begin
            n++;
            step();
        end
        tests++;
        if (n != 10) begin
            fails++;
            $display("FAIL clamp_min: got east green %0d ticks, want 10", n);
        end
        n = 0;
        while (light_s !== G && n < 50) begin
            n++;
            step();
        end
        n = 0;
        while (light_s === G && n < 300) begin
            n++;
            step();
        end
        tests++;
        if (n != 120) begin
            fails++;
            $display("FAIL clamp_max: got south green %0d ticks, want 120", n);
        end
    endtask

    task automatic test_sample_hold();
        int n;
        n = 0;
        while (light_n !== G && n < 100) begin
            n++;
            step();
        end
        n = 0;
        while (light_n === G && n < 300) begin
            n++;
            if (n == 5) TGn = 8'd15;
            step();
        end
        tests++;
        if (n != 40) begin
            fails++;
            $display("FAIL tg_sample_hold: got north green %0d ticks, want 40", n);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        TGe = 8'd30;
        n   = 0;
        while (light_e !== G && n < 50) begin
            n++;
            step();
        end
        repeat (19) step();
        tests++;
        if (light_e !== G || remaining !== 8'd11) begin
            fails++;
            $display("FAIL east_tick20: got e=%b rem=%0d, want 001 11", light_e, remaining);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        tests++;
        if ({light_n, light_e, light_s, light_w} !== {R, R, R, R} || current_road !== 2'd0 ||
            next_road !== 2'd0 || remaining !== 8'd1 || phase_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got %b %b %b %b cur=%0d next=%0d rem=%0d pd=%b, want all 100 0 0 1 0",
                     light_n, light_e, light_s, light_w, current_road, next_road, remaining,
                     phase_done);
        end
        step();
        tests++;
        if (light_n !== G || current_road !== 2'd0 || phase_done !== 1'b1 || remaining !== 8'd15)
        begin
            fails++;
            $display("FAIL restart_north: got n=%b cur=%0d pd=%b rem=%0d, want 001 0 1 15",
                     light_n, current_road, phase_done, remaining);
        end
    endtask

    task automatic test_full_cycle();
        int   seq [5];
        int   k;
        int   cyc;
        int   bad;
        int   cnt;
        logic saw_wrap;
        logic prev_wy;
        logic [1:0] wrap_val;
        TGn = 8'd12;
        TGe = 8'd12;
        TGs = 8'd12;
        TGw = 8'd12;
        k        = 0;
        cyc      = 0;
        bad      = 0;
        saw_wrap = 1'b0;
        prev_wy  = 1'b0;
        wrap_val = 2'd3;
        while (k < 5 && cyc < 1000) begin
            if (phase_done === 1'b1) begin
                seq[k] = int'(current_road);
                k++;
            end
            cnt = int'(light_n !== R) + int'(light_e !== R) + int'(light_s !== R) +
                  int'(light_w !== R);
            if (cnt > 1 || remaining == 8'd0) bad++;
            if (!(light_n inside {R, Y, G}) || !(light_e inside {R, Y, G}) ||
                !(light_s inside {R, Y, G}) || !(light_w inside {R, Y, G})) bad++;
`ifndef ALL_RED_PHASE_EN
            if (cnt != 1) bad++;
`endif
            if (light_w === Y && !prev_wy) begin
                saw_wrap = 1'b1;
                wrap_val = next_road;
            end
            prev_wy = (light_w === Y);
            if (k < 5) step();
            cyc++;
        end
        tests++;
        if (k != 5) begin
            fails++;
            $display("FAIL cycle_pulses: got %0d green entries, want 5", k);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (k == 5 && seq[i] != (i % 4)) begin
                fails++;
                $display("FAIL cycle_road_%0d: got %0d, want %0d", i, seq[i], i % 4);
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL one_nonred_invariant: got %0d bad cycles, want 0", bad);
        end
        tests++;
        if (!saw_wrap || wrap_val !== 2'd0) begin
            fails++;
            $display("FAIL next_road_wrap: got seen=%b next=%0d, want 1 0", saw_wrap, wrap_val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        tick  = 1'b0;
        TGn   = 8'd40;
        TGe   = 8'd0;
        TGs   = 8'd200;
        TGw   = 8'd12;
        test_reset();
        test_basic();
        test_clamp();
        test_sample_hold();
        test_mid_reset();
        test_full_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
